// File: rtl/de_bad_detect_pipe_pkg.sv
// Shared opcode constants, instruction-form masks and code classifiers for
// the decode-stage bad-opcode check.
package de_bad_detect_pipe_pkg;

  localparam logic [5:0] OP_BAD_02 = 6'h02;
  localparam logic [5:0] OP_BAD_03 = 6'h03;
  localparam logic [5:0] OP_BAD_0B = 6'h0B;
  localparam logic [5:0] OP_BAD_14 = 6'h14;
  localparam logic [5:0] OP_BAD_15 = 6'h15;
  localparam logic [5:0] OP_BAD_16 = 6'h16;
  localparam logic [5:0] OP_BAD_17 = 6'h17;
  localparam logic [5:0] OP_BAD_18 = 6'h18;
  localparam logic [5:0] OP_BAD_19 = 6'h19;
  localparam logic [5:0] OP_BAD_1A = 6'h1A;
  localparam logic [5:0] OP_BAD_1B = 6'h1B;
  localparam logic [5:0] OP_BAD_22 = 6'h22;
  localparam logic [5:0] OP_BAD_23 = 6'h23;
  localparam logic [5:0] OP_BAD_2B = 6'h2B;

  // Legal only in the 64-bit form.
  localparam logic [5:0] OP_FSTAR = 6'h3C;
  localparam logic [5:0] OP_LUI   = 6'h3D;
  localparam logic [5:0] OP_JALI  = 6'h3E;
  localparam logic [5:0] OP_JI    = 6'h3F;

  localparam logic [7:0] FORM16_MASK   = 8'h80;
  localparam logic [7:0] FORM16_VAL    = 8'h00;
  localparam logic [7:0] FORMWIDE_MASK = 8'hC0;
  localparam logic [7:0] FORM32_VAL    = 8'h80;
  localparam logic [7:0] FORM64_VAL    = 8'hC0;

  function automatic logic is16(input logic [7:0] op);
    return (op & FORM16_MASK) == FORM16_VAL;
  endfunction

  function automatic logic is32(input logic [7:0] op);
    return (op & FORMWIDE_MASK) == FORM32_VAL;
  endfunction

  function automatic logic is64(input logic [7:0] op);
    return (op & FORMWIDE_MASK) == FORM64_VAL;
  endfunction

  function automatic logic isBadCode(input logic [5:0] code);
    return code inside {OP_BAD_02, OP_BAD_03, OP_BAD_0B, OP_BAD_14, OP_BAD_15, OP_BAD_16,
                        OP_BAD_17, OP_BAD_18, OP_BAD_19, OP_BAD_1A, OP_BAD_1B, OP_BAD_22,
                        OP_BAD_23, OP_BAD_2B};
  endfunction

  function automatic logic isWideOnly(input logic [5:0] code);
    return code inside {OP_FSTAR, OP_LUI, OP_JALI, OP_JI};
  endfunction

endpackage

// File: rtl/de_bad_lane.sv
// Combinational single-byte bad-opcode classifier; a disabled lane is never bad.
module de_bad_lane
  import de_bad_detect_pipe_pkg::*;
(
  input  logic [7:0] op,
  input  logic       en,
  output logic       bad
);

  always_comb begin
    bad = 1'b0;
    if (en) begin
      if (is16(op)) begin
        bad = (op[6:4] == 3'h7);
      end else if (is32(op)) begin
        bad = isBadCode(op[5:0]) | isWideOnly(op[5:0]);
      end else if (is64(op)) begin
        bad = isBadCode(op[5:0]);
      end
    end
  end

endmodule

// File: rtl/de_bad_detect_pipe.sv
// One registered stage classifying LANES opcode bytes per group, with sticky
// first-fault capture and a saturating bad-lane counter updated on delivery.
module de_bad_detect_pipe
  import de_bad_detect_pipe_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LANE_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*8-1:0]   in_ops,
  input  logic [LANES-1:0]     in_lane_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*8-1:0]   out_ops,
  output logic [LANES-1:0]     out_lane_en,
  output logic [LANES-1:0]     out_bad,
  output logic                 out_any_bad,
  output logic                 flt_valid,
  output logic [LANE_W-1:0]    flt_lane,
  output logic [7:0]           flt_op,
  output logic [CNT_W-1:0]     flt_count,
  input  logic                 flt_clear
);

  localparam logic [CNT_W+3:0] CntMax = {4'b0, {CNT_W{1'b1}}};

  logic [LANES-1:0]  laneBad;
  logic              inXfer;
  logic              outXfer;
  logic              fltValidD;
  logic [LANE_W-1:0] fltLaneD;
  logic [7:0]        fltOpD;
  logic [CNT_W-1:0]  fltCountD;
  logic [LANE_W-1:0] badIdx;
  logic [7:0]        badOp;
  logic [CNT_W+3:0]  cntSum;

  function automatic logic [3:0] popCount(input logic [LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(LANES); i++) n = n + {3'b0, v[i]};
    return n;
  endfunction

  function automatic logic [LANE_W-1:0] firstBad(input logic [LANES-1:0] v);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (v[i]) idx = LANE_W'(i);
    end
    return idx;
  endfunction

  for (genvar g = 0; g < int'(LANES); g++) begin : gLane
    de_bad_lane uLane (
      .op  (in_ops[8*g +: 8]),
      .en  (in_lane_en[g]),
      .bad (laneBad[g])
    );
  end

  assign in_ready = ~out_valid | out_ready;
  assign inXfer   = in_valid & in_ready;
  assign outXfer  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_ops     <= '0;
      out_lane_en <= '0;
      out_bad     <= '0;
      out_any_bad <= 1'b0;
    end else if (inXfer) begin
      out_valid   <= 1'b1;
      out_ops     <= in_ops;
      out_lane_en <= in_lane_en;
      out_bad     <= laneBad;
      out_any_bad <= |laneBad;
    end else if (outXfer) begin
      out_valid <= 1'b0;
    end
  end

  // Clear applies first so a same-cycle delivery captures into cleared state.
  always_comb begin
    badIdx = firstBad(out_bad);
    badOp  = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (out_bad[i]) badOp = out_ops[8*i +: 8];
    end
    fltValidD = flt_valid;
    fltLaneD  = flt_lane;
    fltOpD    = flt_op;
    fltCountD = flt_count;
    cntSum    = '0;
    if (flt_clear) begin
      fltValidD = 1'b0;
      fltLaneD  = '0;
      fltOpD    = '0;
      fltCountD = '0;
    end
    if (outXfer) begin
      cntSum    = {4'b0, fltCountD} + {{CNT_W{1'b0}}, popCount(out_bad)};
      fltCountD = (cntSum > CntMax) ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];
      if (out_any_bad && !fltValidD) begin
        fltValidD = 1'b1;
        fltLaneD  = badIdx;
        fltOpD    = badOp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_valid <= 1'b0;
      flt_lane  <= '0;
      flt_op    <= '0;
      flt_count <= '0;
    end else begin
      flt_valid <= fltValidD;
      flt_lane  <= fltLaneD;
      flt_op    <= fltOpD;
      flt_count <= fltCountD;
    end
  end

endmodule

// File: tb/tb_de_bad_detect_pipe.sv
// Self-checking bench for de_bad_detect_pipe: vector table, hand sequences
// and a randomized stream against a behavioural reference model.
module tb_de_bad_detect_pipe;

  localparam int unsigned LANES  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned LANE_W = 3;
  localparam int          CntMax = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*8-1:0]   in_ops;
  logic [LANES-1:0]     in_lane_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*8-1:0]   out_ops;
  logic [LANES-1:0]     out_lane_en;
  logic [LANES-1:0]     out_bad;
  logic                 out_any_bad;
  logic                 flt_valid;
  logic [LANE_W-1:0]    flt_lane;
  logic [7:0]           flt_op;
  logic [CNT_W-1:0]     flt_count;
  logic                 flt_clear;

  int checks   = 0;
  int failures = 0;

  de_bad_detect_pipe #(
    .LANES  (LANES),
    .CNT_W  (CNT_W),
    .LANE_W (LANE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ops      (in_ops),
    .in_lane_en  (in_lane_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ops     (out_ops),
    .out_lane_en (out_lane_en),
    .out_bad     (out_bad),
    .out_any_bad (out_any_bad),
    .flt_valid   (flt_valid),
    .flt_lane    (flt_lane),
    .flt_op      (flt_op),
    .flt_count   (flt_count),
    .flt_clear   (flt_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference classifier from the opcode-form rules.
  function automatic bit refBad(input logic [7:0] b, input bit en);
    int unsigned badList[14];
    int unsigned wideOnly[4];
    int unsigned code;
    badList  = '{'h02, 'h03, 'h0B, 'h14, 'h15, 'h16, 'h17, 'h18, 'h19, 'h1A, 'h1B,
                 'h22, 'h23, 'h2B};
    wideOnly = '{'h3C, 'h3D, 'h3E, 'h3F};
    if (!en) return 1'b0;
    if (b[7] == 1'b0) return b[6:4] == 3'd7;
    code = 32'(b[5:0]);
    foreach (badList[k]) if (code == badList[k]) return 1'b1;
    if (b[6] == 1'b0) begin
      foreach (wideOnly[k]) if (code == wideOnly[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flt_clear = 1'b0;
    in_ops = '0;
    in_lane_en = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();
  endtask

  typedef struct {
    logic [15:0] ops;
    logic [1:0]  en;
    logic [1:0]  bad;
  } vec_t;

  vec_t vecs[8];

  bit          mValid;
  logic [15:0] mOps;
  logic [1:0]  mBad;
  bit          mFv;
  int          mLane;
  logic [7:0]  mOp;
  int          mCnt;
  bit          outX;
  bit          inX;
  bit          expReady;

  initial begin
    vecs[0] = '{16'h8101, 2'b11, 2'b00};
    vecs[1] = '{16'h7082, 2'b11, 2'b11};
    vecs[2] = '{16'h01BF, 2'b11, 2'b01};  // JI, 32-bit form
    vecs[3] = '{16'h00FF, 2'b11, 2'b00};  // JI, 64-bit form
    vecs[4] = '{16'h9470, 2'b10, 2'b10};  // bad byte in disabled lane 0
    vecs[5] = '{16'h3FE2, 2'b11, 2'b01};
    vecs[6] = '{16'hFD7F, 2'b11, 2'b01};
    vecs[7] = '{16'hABBC, 2'b11, 2'b11};

    doReset();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_bad", 32'(out_bad), 32'd0);
    chk("reset_out_ops", 32'(out_ops), 32'd0);
    chk("reset_flt_valid", 32'(flt_valid), 32'd0);
    chk("reset_flt_count", 32'(flt_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Table: back-to-back groups at full rate
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_ops = vecs[i].ops;
      in_lane_en = vecs[i].en;
      step();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_out_bad", i), 32'(out_bad), 32'(vecs[i].bad));
      chk($sformatf("vec%0d_any_bad", i), 32'(out_any_bad), 32'(|vecs[i].bad));
    end
    in_valid = 1'b0;
    step();

    // Legal group then a two-lane bad group
    doReset();
    in_valid = 1'b1; in_ops = 16'h8101; in_lane_en = 2'b11;
    step();
    chk("legal_out_valid", 32'(out_valid), 32'd1);
    chk("legal_out_bad", 32'(out_bad), 32'd0);
    chk("legal_flt_valid", 32'(flt_valid), 32'd0);
    chk("legal_flt_count", 32'(flt_count), 32'd0);
    in_ops = 16'h7082;
    step();
    in_valid = 1'b0;
    chk("pair_out_bad", 32'(out_bad), 32'h3);
    step();
    chk("pair_flt_valid", 32'(flt_valid), 32'd1);
    chk("pair_flt_lane", 32'(flt_lane), 32'd0);
    chk("pair_flt_op", 32'(flt_op), 32'h82);
    chk("pair_flt_count", 32'(flt_count), 32'd2);
    chk("pair_drained", 32'(out_valid), 32'd0);

    // Clear alone
    flt_clear = 1'b1;
    step();
    flt_clear = 1'b0;
    chk("clr_flt_valid", 32'(flt_valid), 32'd0);
    chk("clr_flt_lane", 32'(flt_lane), 32'd0);
    chk("clr_flt_op", 32'(flt_op), 32'd0);
    chk("clr_flt_count", 32'(flt_count), 32'd0);

    // Stall for 5 cycles, then release
    out_ready = 1'b0;
    in_valid = 1'b1; in_ops = 16'h0182; in_lane_en = 2'b11;
    step();
    in_ops = 16'h7070;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_bad", 32'(out_bad), 32'h1);
      chk("stall_out_ops", 32'(out_ops), 32'h0182);
      chk("stall_flt_count", 32'(flt_count), 32'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_flt_count", 32'(flt_count), 32'd1);
    chk("release_flt_op", 32'(flt_op), 32'h82);
    step();
    chk("release_once", 32'(flt_count), 32'd1);

    // Saturation: 1 + 2 + 2 bad lanes with a 2-bit counter
    in_valid = 1'b1; in_ops = 16'h7082; in_lane_en = 2'b11;
    step();
    step();
    in_valid = 1'b0;
    chk("sat_mid_count", 32'(flt_count), 32'd3);
    step();
    chk("sat_count", 32'(flt_count), 32'd3);
    chk("sat_flt_op_held", 32'(flt_op), 32'h82);

    // Clear in the same cycle as a bad delivery
    in_valid = 1'b1; in_ops = 16'h0183; in_lane_en = 2'b11;
    step();
    in_valid = 1'b0;
    flt_clear = 1'b1;
    step();
    flt_clear = 1'b0;
    chk("clrcap_flt_valid", 32'(flt_valid), 32'd1);
    chk("clrcap_flt_op", 32'(flt_op), 32'h83);
    chk("clrcap_flt_lane", 32'(flt_lane), 32'd0);
    chk("clrcap_flt_count", 32'(flt_count), 32'd1);

    // Randomized stream against the reference model
    doReset();
    mValid = 0; mOps = '0; mBad = '0; mFv = 0; mLane = 0; mOp = '0; mCnt = 0;
    for (int c = 0; c < 80; c++) begin
      in_valid = (c < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      out_ready = (c < 16) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      in_ops = 16'($urandom);
      in_lane_en = 2'($urandom);
      flt_clear = (c >= 16) && ($urandom_range(0, 15) == 0);
      #1;
      expReady = !mValid || out_ready;
      chk("rnd_in_ready", 32'(in_ready), 32'(expReady));
      chk("rnd_out_valid", 32'(out_valid), 32'(mValid));
      if (mValid) begin
        chk("rnd_out_bad", 32'(out_bad), 32'(mBad));
        chk("rnd_out_ops", 32'(out_ops), 32'(mOps));
        chk("rnd_out_any_bad", 32'(out_any_bad), 32'(mBad != 0));
      end
      chk("rnd_flt_valid", 32'(flt_valid), 32'(mFv));
      chk("rnd_flt_count", 32'(flt_count), 32'(mCnt));
      if (mFv) begin
        chk("rnd_flt_lane", 32'(flt_lane), 32'(mLane));
        chk("rnd_flt_op", 32'(flt_op), 32'(mOp));
      end
      outX = mValid && out_ready;
      inX = in_valid && expReady;
      if (flt_clear) begin
        mFv = 0; mLane = 0; mOp = '0; mCnt = 0;
      end
      if (outX) begin
        mCnt = mCnt + $countones(mBad);
        if (mCnt > CntMax) mCnt = CntMax;
        for (int l = 0; l < int'(LANES); l++) begin
          if (!mFv && mBad[l]) begin
            mFv = 1; mLane = l; mOp = mOps[8*l +: 8];
          end
        end
      end
      if (inX) begin
        mValid = 1;
        mOps = in_ops;
        for (int l = 0; l < int'(LANES); l++) mBad[l] = refBad(in_ops[8*l +: 8], in_lane_en[l]);
      end else if (outX) begin
        mValid = 0;
      end
      step();
    end

    // Asynchronous reset while a group is stalled
    flt_clear = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ops = 16'h7082; in_lane_en = 2'b11;
    step();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_bad", 32'(out_bad), 32'd0);
    chk("async_rst_flt_count", 32'(flt_count), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_flt_valid", 32'(flt_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/de_bad_detect_pipe.md
Name: de_bad_detect_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage bad-opcode check.
- Classifies LANES opcode bytes per fetch group in one registered stage behind a valid/ready handshake.
- Maintains a sticky first-fault capture and a saturating bad-opcode counter for the exception/debug path.
- Sits between fetch-group alignment and the decode lanes; the downstream decoder consumes the per-lane bad flags.

Parameters:
- LANES, 2, number of opcode bytes (instruction slots) checked per transfer; legal range 1..8.
- CNT_W, 8, width of the saturating bad-opcode counter.
- LANE_W, 3, width of the captured lane index; must satisfy 2^LANE_W >= LANES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream group valid
- in_ready  out  1  stage can accept a group
- in_ops  in  LANES*8  opcode bytes (bits [63:56] of each instruction); lane i at [8i+7:8i]
- in_lane_en  in  LANES  lane contains a real instruction
- out_valid  out  1  registered group valid
- out_ready  in  1  downstream accepts
- out_ops  out  LANES*8  registered copy of in_ops
- out_lane_en  out  LANES  registered copy of in_lane_en
- out_bad  out  LANES  per-lane bad-opcode flag
- out_any_bad  out  1  OR of out_bad
- flt_valid  out  1  sticky: a bad opcode has been captured
- flt_lane  out  LANE_W  lane index of the captured fault
- flt_op  out  8  captured opcode byte
- flt_count  out  CNT_W  saturating count of bad lanes delivered
- flt_clear  in  1  synchronous clear of flt_* state

Behaviour:
- Reset (async, rst=1): out_valid=0; out_ops, out_lane_en, out_bad, out_any_bad = 0; flt_valid=0, flt_lane=0, flt_op=0, flt_count=0.
- Per-lane classification is combinational on in_ops and is registered into the stage. With byte b:
  - 16-bit form (b[7]=0): bad iff b[6:4]==3'h7.
  - 32-bit (b[7:6]=2'b10) and 64-bit (b[7:6]=2'b11) forms: bad iff b[5:0] is any OP_BAD_xx code from de_isa_def.vh (02,03,0B,14–1B,22,23,2B).
  - FSTAR, LUI, JALI and JI are bad in 32-bit form only; they are legal in 64-bit form.
  - A lane with in_lane_en=0 is never bad.
- Handshake: in_ready = ~out_valid | out_ready.
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle; throughput is one group per cycle with no bubbles while out_ready=1.
  - On an input transfer, load out_ops, out_lane_en and out_bad, and set out_valid=1.
  - On an output transfer with no input transfer, set out_valid=0.
  - While stalled (out_valid & ~out_ready), all out_* signals hold stable.
- Fault capture is evaluated on the output transfer only, so a stalled group is never counted twice.
  - If flt_valid=0 and the delivered group has any bad lane, capture the lowest-index bad lane (flt_lane, flt_op) and set flt_valid=1.
  - If flt_valid=1, flt_lane and flt_op hold their first-fault values.
  - flt_count += popcount(out_bad) on each output transfer, saturating at 2^CNT_W-1 with no wrap.
- flt_clear=1 zeroes flt_valid, flt_lane, flt_op and flt_count, except when a bad group is delivered in the same cycle:
  - the new group's fault is captured instead (flt_valid=1, count=popcount);
  - the capture always wins over the clear.
- Reset asserted mid-stall discards the held group; no transfer is reported after rst deasserts until a new in_valid arrives.

Decomposition:
- Opcode constants stay in the shared de_isa_def.vh include; no new constants are introduced.
- A form-decode helper (is16/is32/is64) is added to that header as localparam masks.
- One sub-module: de_bad_lane, a purely combinational single-byte classifier (inputs: 8-bit op and enable; output: bad).
  - It is instantiated LANES times in a generate loop.
  - The original single-lane check is re-expressed through it.
- The popcount and lowest-index priority encoder are local functions inside de_bad_detect_pipe.

Test Plan:
- Reset then a legal group (LANES=2: ops 8'h01, 8'h81, both enabled) -> one cycle later out_valid=1, out_bad=2'b00, flt_valid=0, flt_count=0.
- Group {lane1=8'h70, lane0=8'h82} enabled, out_ready=1 -> out_bad=2'b11, flt_lane=0, flt_op=8'h82, flt_count=2.
- 32- vs 64-bit special opcodes: lane0=JI in 32-bit form (b[7:6]=10) -> bad; same code with b[7:6]=11 -> not bad. Disabled lane holding 8'h70 -> not bad.
- Stall: bad group held with out_ready=0 for 5 cycles -> in_ready=0, outputs stable, flt_count unchanged. Release -> flt_count increments once.
- Saturation with CNT_W=2: deliver 5 bad lanes -> flt_count stops at 3. flt_clear alone -> all flt_* = 0. flt_clear in the same cycle as a delivered bad lane (op 8'h83) -> flt_valid=1, flt_op=8'h83, flt_count=1.
- Back-to-back full-rate stream of 16 random groups with out_ready=1 -> per-cycle out_bad matches a reference model; assert rst mid-stream -> out_valid drops to 0 immediately (async).
